// File: rtl/ping_pong_ctrl_if.sv
// Producer/consumer handshake and dual-bank buffer control bundle
// shared by the ping-pong controller and whatever sits around it.
interface ping_pong_ctrl_if #(
  parameter int AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] addr1w;
  logic          we1;
  logic [AW-1:0] addr1r;
  logic [AW-1:0] addr2;
  logic          we2;
  logic          ping_pong;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          bank_swap;

  modport master (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output addr1w,
    output we1,
    output addr1r,
    output addr2,
    output we2,
    output ping_pong,
    output out_valid,
    output out_last,
    output bank_swap
  );

  modport slave (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  addr1w,
    input  we1,
    input  addr1r,
    input  addr2,
    input  we2,
    input  ping_pong,
    input  out_valid,
    input  out_last,
    input  bank_swap
  );
endinterface

// File: rtl/ping_pong_ctrl.sv
// Ping-pong frame buffer controller: producer fills one bank while
// the consumer drains the other; banks swap on whole frames only.
module ping_pong_ctrl #(
  parameter int DEPTH = 16,
  parameter int LEN   = 16
) (
  input  logic             clk,
  input  logic             rst,
  ping_pong_ctrl_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam logic [AW-1:0] WR_LAST = AW'(LEN - 1);
  localparam logic [PW-1:0] RD_LAST = PW'(LEN - 1);
  localparam logic [PW-1:0] RD_END  = PW'(LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

  rd_state_t     state_q;
  rd_state_t     state_d;
  logic          wr_full;
  logic [AW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] iss_ptr;
  logic          rd_full;
  logic          advance;
  logic          swap;
  logic          out_done;
  logic [AW-1:0] addr2_d;
  logic          ping_pong_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          bank_swap_q;

  assign rd_full  = (state_q == DRAIN);
  assign swap     = wr_full && !rd_full && !out_valid_q;
  assign out_done = out_valid_q && bus.out_ready && out_last_q;

  assign bus.in_ready  = !wr_full && !rst;
  assign bus.we1       = bus.in_valid && bus.in_ready;
  assign bus.addr1w    = wr_ptr;
  assign bus.addr1r    = '0;
  assign bus.we2       = 1'b0;
  assign bus.addr2     = addr2_d;
  assign bus.ping_pong = ping_pong_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.bank_swap = bank_swap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      wr_full <= 1'b0;
    end else if (swap) begin
      wr_ptr  <= '0;
      wr_full <= 1'b0;
    end else if (bus.we1) begin
      if (wr_ptr == WR_LAST) begin
        wr_ptr  <= '0;
        wr_full <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (swap)     state_d = DRAIN;
      DRAIN: if (out_done) state_d = IDLE;
    endcase
  end

  // A stalled word keeps its own address so dout2 stays put.
  always_comb begin
    advance = 1'b0;
    addr2_d = iss_ptr;
    if (rd_full && (rd_ptr != RD_END) &&
        (!out_valid_q || bus.out_ready)) begin
      advance = 1'b1;
    end
    if (advance) addr2_d = rd_ptr[AW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      iss_ptr     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (swap || out_done) rd_ptr <= '0;
      else if (advance)     rd_ptr <= rd_ptr + 1'b1;
      if (advance) begin
        out_valid_q <= 1'b1;
        iss_ptr     <= rd_ptr[AW-1:0];
        out_last_q  <= (rd_ptr == RD_LAST);
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ping_pong_q <= 1'b1;
      bank_swap_q <= 1'b0;
    end else begin
      bank_swap_q <= swap;
      if (swap) ping_pong_q <= !ping_pong_q;
    end
  end
endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Bench for ping_pong_ctrl: buffer model, frame-level scoreboard
// and directed scenarios with hand-computed timing.
module tb_ping_pong_ctrl;
  localparam int DEPTH = 8;
  localparam int LEN   = 4;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ping_pong_ctrl_if #(.AW(AW)) bus();

  ping_pong_ctrl #(.DEPTH(DEPTH), .LEN(LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] mem [2][DEPTH];
  logic [7:0] din1;
  logic [7:0] dout2;

  always @(posedge clk) begin
    if (bus.we1) mem[bus.ping_pong][bus.addr1w] <= din1;
    dout2 <= mem[!bus.ping_pong][bus.addr2];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int         sw_log[$];
  logic       pp_log[$];
  int         out_cyc[$];
  logic [7:0] out_dat[$];
  logic       out_lst[$];
  int         acc_cyc[$];
  logic       ir_log[4096];
  int         cyc_n   = 0;
  int         acc     = 0;
  int         swaps   = 0;
  int         emitted = 0;
  int         pend;
  logic       pp_prev = 1'b1;
  logic       stall   = 1'b0;
  logic [7:0] hold_d;

  always @(negedge clk) begin
    cyc_n++;
    if (cyc_n < 4096) ir_log[cyc_n] = bus.in_ready;
    if (rst) begin
      exp_q.delete();
      acc = 0;
      swaps = 0;
      emitted = 0;
      pp_prev = 1'b1;
      stall = 1'b0;
    end else begin
      if (bus.bank_swap) begin
        swaps++;
        sw_log.push_back(cyc_n);
        pp_log.push_back(bus.ping_pong);
        chk("swap_after_drain", emitted, LEN * (swaps - 1));
      end
      chk("swap_pulse", bus.bank_swap, bus.ping_pong != pp_prev);
      pend = acc - LEN * swaps;
      chk("in_ready", bus.in_ready, pend < LEN);
      chk("we1", bus.we1, bus.in_valid && (pend < LEN));
      if (bus.we1) begin
        exp_q.push_back(din1);
        acc++;
        acc_cyc.push_back(cyc_n);
      end
      if (stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", dout2, hold_d);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_extra: got %0h expected none", dout2);
        end else begin
          chk("out_data", dout2, exp_q.pop_front());
          chk("out_last", bus.out_last,
              (emitted % LEN) == (LEN - 1));
        end
        emitted++;
        out_cyc.push_back(cyc_n);
        out_dat.push_back(dout2);
        out_lst.push_back(bus.out_last);
      end
      stall   = bus.out_valid && !bus.out_ready;
      hold_d  = dout2;
      pp_prev = bus.ping_pong;
    end
  end

  logic [7:0] word;

  task automatic cyc(input logic v, input logic r);
    bus.in_valid  = v;
    bus.out_ready = r;
    din1 = word;
    @(negedge clk);
    if (bus.we1) word++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int         w0;
  int         na;
  int         no;
  int         ns;
  logic [7:0] base;
  logic [7:0] tgt;

  initial begin
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    word = 8'h10;
    din1 = word;
    #1 rst = 1'b1;
    #1;
    chk("rst_ping_pong", bus.ping_pong, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_bank_swap", bus.bank_swap, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_we1", bus.we1, 0);
    chk("rst_addr1w", bus.addr1w, 0);
    chk("rst_addr2", bus.addr2, 0);
    chk("rst_addr1r", bus.addr1r, 0);
    chk("rst_we2", bus.we2, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1);

    // Basic frame: A..D back-to-back
    base = word;
    na = acc_cyc.size();
    no = out_cyc.size();
    ns = sw_log.size();
    for (int i = 0; i < LEN; i++) cyc(1, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1);
    w0 = acc_cyc[na];
    chk("s1_swaps", sw_log.size() - ns, 1);
    chk("s1_swap_cyc", sw_log[ns], w0 + 5);
    chk("s1_out_cnt", out_cyc.size() - no, 4);
    for (int i = 0; i < 4; i++) begin
      chk("s1_out_cyc", out_cyc[no + i], w0 + 6 + i);
      chk("s1_out_dat", out_dat[no + i], base + 8'(i));
      chk("s1_out_lst", out_lst[no + i], i == 3);
    end
    chk("s1_ping_pong", bus.ping_pong, 0);

    // Backpressure on word B
    base = word;
    na = acc_cyc.size();
    no = out_cyc.size();
    for (int i = 0; i < LEN; i++) cyc(1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("s2_stall_valid", bus.out_valid, 1);
      chk("s2_stall_addr2", bus.addr2, 1);
      chk("s2_stall_dout", dout2, base + 8'd1);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 6; i++) cyc(0, 1);
    w0 = acc_cyc[na];
    chk("s2_out_cnt", out_cyc.size() - no, 4);
    chk("s2_cyc_a", out_cyc[no], w0 + 6);
    chk("s2_cyc_b", out_cyc[no + 1], w0 + 10);
    chk("s2_cyc_c", out_cyc[no + 2], w0 + 11);
    chk("s2_cyc_d", out_cyc[no + 3], w0 + 12);
    chk("s2_dat_d", out_dat[no + 3], base + 8'd3);
    chk("s2_ping_pong", bus.ping_pong, 1);

    // Continuous streaming of three frames
    base = word;
    tgt = base + 8'd12;
    na = acc_cyc.size();
    no = out_cyc.size();
    ns = sw_log.size();
    for (int k = 0; k < 200 && word != tgt; k++) cyc(1, 1);
    chk("s3_accepted", word, tgt);
    for (int i = 0; i < 12; i++) cyc(0, 1);
    w0 = acc_cyc[na];
    chk("s3_swaps", sw_log.size() - ns, 3);
    chk("s3_pp0", pp_log[ns], 0);
    chk("s3_pp1", pp_log[ns + 1], 1);
    chk("s3_pp2", pp_log[ns + 2], 0);
    chk("s3_period1", sw_log[ns + 1] - sw_log[ns], LEN + 2);
    chk("s3_period2", sw_log[ns + 2] - sw_log[ns + 1], LEN + 2);
    chk("s3_ready_w4", ir_log[w0 + 4], 0);
    chk("s3_ready_w9", ir_log[w0 + 9], 0);
    chk("s3_ready_w10", ir_log[w0 + 10], 0);
    chk("s3_ready_w11", ir_log[w0 + 11], 1);
    chk("s3_out_cnt", out_cyc.size() - no, 12);
    chk("s3_last_dat", out_dat[no + 11], base + 8'd11);

    // Reset mid-drain after word B
    no = out_cyc.size();
    for (int i = 0; i < LEN; i++) cyc(1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1);
    chk("s4_pre_cnt", out_cyc.size() - no, 2);
    rst = 1'b1;
    #1;
    chk("s4_rst_valid", bus.out_valid, 0);
    chk("s4_rst_pp", bus.ping_pong, 1);
    chk("s4_rst_ready", bus.in_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    no = out_cyc.size();
    ns = sw_log.size();
    for (int i = 0; i < 10; i++) cyc(0, 1);
    chk("s4_quiet_out", out_cyc.size() - no, 0);
    chk("s4_quiet_swap", sw_log.size() - ns, 0);
    chk("s4_quiet_pp", bus.ping_pong, 1);
    base = word;
    for (int i = 0; i < LEN; i++) cyc(1, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1);
    chk("s4_new_cnt", out_cyc.size() - no, 4);
    chk("s4_new_first", out_dat[no], base);
    chk("s4_new_pp", bus.ping_pong, 0);

    // Random gaps on both sides
    base = word;
    tgt = base + 8'd12;
    no = out_cyc.size();
    for (int k = 0; k < 500 && word != tgt; k++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("s5_accepted", word, tgt);
    for (int i = 0; i < 30; i++) cyc(0, 1);
    chk("s5_out_cnt", out_cyc.size() - no, 12);
    chk("s5_model_empty", exp_q.size(), 0);
    chk("s5_last_dat", out_dat[no + 11], base + 8'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
